// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial packed-BCD adder.
// Includes the FSM state encoding, the decimal correction constants and a digit validity test.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational one-digit BCD adder with decimal carry in and carry out.
// The widest sum is 9 + 9 + 1 = 19, so a 5-bit intermediate is always enough.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    if (t > {1'b0, BCD_MAX}) begin
      // Adding 6 skips the six unused codes; dropping bit 4 leaves the decimal digit.
      s  = t[3:0] + BCD_CORR;
      co = 1'b1;
    end else begin
      s  = t[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit per clock, LSD first, through one bcd_digit_add.
// Define BCD_CHECK_EN to flag operands that contain non-BCD nibbles on err.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NDIGITS-1:0] a,
  input  logic [4*NDIGITS-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NDIGITS-1:0] sum,
  output logic                 cout,
  output logic                 err
);

  localparam int CNT_W = $clog2(NDIGITS) + 1;
  localparam int W     = 4 * NDIGITS;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [3:0]         dig_a, dig_b, dig_s;
  logic               dig_co;
  logic               accept;

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == CNT_W'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
  end

  bcd_digit_add u_digit (
    .a  (dig_a),
    .b  (dig_b),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  always_comb begin
    // NOTE: every _d is given its hold value first so no path through this block infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADD;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end
      ADD: begin
        for (int i = 0; i < NDIGITS; i++) begin
          if (idx_q == CNT_W'(i)) sum_d[4*i +: 4] = dig_s;
        end
        carry_d = dig_co;
        idx_d   = idx_q + CNT_W'(1);
        if (idx_q == CNT_W'(NDIGITS - 1)) begin
          state_d = DONE;
          cout_d  = dig_co;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: operand registers are reset too; a reset mid-operation must leave no stale digits.
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

`ifdef BCD_CHECK_EN
  logic err_q, err_d, bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4])) bad_digit = 1'b1;
    end
    err_d = accept ? bad_digit : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (NDIGITS=4); outputs are sampled on the falling edge.
// Expected err follows BCD_CHECK_EN when the bench is built with that macro.
module tb_bcd_serial_add_ctrl;

  logic        clk, rst, start, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, err;
  logic [15:0] sum;

  int checks = 0;
  int errors = 0;

  bcd_serial_add_ctrl #(.NDIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BCD_CHECK_EN
  localparam logic BAD_ERR = 1'b1;
`else
  localparam logic BAD_ERR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge of ADD cycle 1.
  task automatic kick(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'hFFFF; b = 16'hEEEE; cin = ~cv;
  endtask

  // Samples from the current falling edge (ADD cycle cyc0) until done; returns in the DONE cycle.
  task automatic wait_done(input string tag, input int cyc0, input logic chk_sum,
                           input logic [15:0] exp_sum, input logic exp_cout, input logic exp_err);
    int cyc = cyc0;
    int busy_n = 0;
    bit seen = 0;
    while (!seen && cyc <= 20) begin
      if (busy) busy_n++;
      if (done) seen = 1;
      else begin
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    check({tag, "_done_cycle"}, cyc, 5);
    check({tag, "_busy_cycles"}, busy_n, 6 - cyc0);
    if (chk_sum) begin
      check({tag, "_sum"}, sum, exp_sum);
      check({tag, "_cout"}, cout, exp_cout);
    end
    check({tag, "_err"}, err, exp_err);
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum",  sum,  0);
    check("reset_cout", cout, 0);
    check("reset_err",  err,  0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic add, latency, hold after done
    kick(16'h1234, 16'h5678, 1'b0);
    wait_done("t1", 1, 1'b1, 16'h6912, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_sum_held", sum, 16'h6912);

    // 2: carry ripple through all digits, and the maximum case
    kick(16'h9999, 16'h0001, 1'b0);
    wait_done("t2a", 1, 1'b1, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    kick(16'h9999, 16'h9999, 1'b1);
    wait_done("t2b", 1, 1'b1, 16'h9999, 1'b1, 1'b0);
    @(negedge clk);

    // 3: carry-in only; start during DONE ignored, next start in IDLE accepted
    kick(16'h0000, 16'h0000, 1'b1);
    wait_done("t3", 1, 1'b1, 16'h0001, 1'b0, 1'b0);
    a = 16'h1111; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_done_start_ignored", busy, 0);
    check("t3_sum_kept", sum, 16'h0001);
    kick(16'h2500, 16'h2500, 1'b1);
    wait_done("t3b", 1, 1'b1, 16'h5001, 1'b0, 1'b0);
    @(negedge clk);

    // 4: start during ADD ignored
    kick(16'h0456, 16'h0789, 1'b0);
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    wait_done("t4", 2, 1'b1, 16'h1245, 1'b0, 1'b0);
    @(negedge clk);

    // 5: reset in ADD cycle 2 aborts with no done
    kick(16'h1234, 16'h5678, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_sum",  sum,  0);
    check("t5_cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("t5_no_done", saw_done, 0);
    kick(16'h5000, 16'h5000, 1'b0);
    wait_done("t5b", 1, 1'b1, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);

    // 6: non-BCD operand detection
    kick(16'h00A0, 16'h0001, 1'b0);
    wait_done("t6a", 1, 1'b0, 16'h0000, 1'b0, BAD_ERR);
    @(negedge clk);
    check("t6_err_held", err, BAD_ERR);
    kick(16'h0042, 16'h0058, 1'b0);
    wait_done("t6b", 1, 1'b1, 16'h0100, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
